// File: rtl/midori_sbox_pkg.sv
// Shared types and constants for the Midori masked S-box scheduler.
// Optional build macro used by the top: SBOX_IDLE_ZERO_EN.
package midori_sbox_pkg;

  localparam int NIB_W   = 4;
  localparam int NUM_NIB = 16;
  localparam int STATE_W = 64;
  localparam int R_W     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic             valid;
    logic [NIB_W-1:0] idx;
  } tag_t;

  // Selects nibble i (bits [4i+3:4i]) of one share.
  function automatic logic [NIB_W-1:0] get_nib(input logic [STATE_W-1:0] s,
                                               input logic [3:0]         i);
    return s[{i, 2'b00} +: NIB_W];
  endfunction

endpackage

// File: rtl/midori_sbox_sched_tag_pipe.sv
// LAT-deep valid/index shift register that follows nibbles through the shared S-box.
module sbox_tag_pipe
  import midori_sbox_pkg::*;
#(
  parameter int LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t pipe_q [LAT];
  tag_t pipe_d [LAT];

  // Advances every cycle, independent of the scheduler state.
  always_comb begin
    pipe_d[0] = tag_in;
    for (int i = 1; i < LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LAT; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign tag_out = pipe_q[LAT-1];

endmodule

// File: rtl/midori_sbox_sched.sv
// Shares one 3-share masked Midori S-box across the 16 nibbles of a shared state.
// Build option: SBOX_IDLE_ZERO_EN forces sb_in* to zero in every non-issue cycle.
module midori_sbox_sched #(
  parameter int LAT     = 4,
  parameter int NUM_NIB = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] st_in1,
  input  logic [63:0] st_in2,
  input  logic [63:0] st_in3,
  output logic        busy,
  output logic        done,
  output logic [63:0] st_out1,
  output logic [63:0] st_out2,
  output logic [63:0] st_out3,
  input  logic [7:0]  rnd,
  input  logic        rnd_valid,
  output logic        rnd_ready,
  output logic [3:0]  sb_in1,
  output logic [3:0]  sb_in2,
  output logic [3:0]  sb_in3,
  output logic [7:0]  sb_r,
  input  logic [3:0]  sb_out1,
  input  logic [3:0]  sb_out2,
  input  logic [3:0]  sb_out3
);
  import midori_sbox_pkg::*;

  sched_state_t       state_q, state_d;
  logic [4:0]         issue_cnt_q, issue_cnt_d;
  logic [4:0]         wb_cnt_q, wb_cnt_d;
  logic [STATE_W-1:0] buf1_q, buf1_d, buf2_q, buf2_d, buf3_q, buf3_d;
  logic [STATE_W-1:0] st1_q, st1_d, st2_q, st2_d, st3_q, st3_d;
  logic               issue_s;
  tag_t               tag_in_s, tag_out_s;
  logic [NIB_W-1:0]   nib1_s, nib2_s, nib3_s;

  assign nib1_s = get_nib(buf1_q, issue_cnt_q[3:0]);
  assign nib2_s = get_nib(buf2_q, issue_cnt_q[3:0]);
  assign nib3_s = get_nib(buf3_q, issue_cnt_q[3:0]);

  // Write-back happens first so a start in IDLE can still clear wb_cnt.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    wb_cnt_d    = wb_cnt_q;
    buf1_d      = buf1_q;
    buf2_d      = buf2_q;
    buf3_d      = buf3_q;
    st1_d       = st1_q;
    st2_d       = st2_q;
    st3_d       = st3_q;
    issue_s     = 1'b0;
    tag_in_s    = '0;

    if (tag_out_s.valid) begin
      st1_d[{tag_out_s.idx, 2'b00} +: NIB_W] = sb_out1;
      st2_d[{tag_out_s.idx, 2'b00} +: NIB_W] = sb_out2;
      st3_d[{tag_out_s.idx, 2'b00} +: NIB_W] = sb_out3;
      wb_cnt_d = wb_cnt_q + 5'd1;
    end else begin
      wb_cnt_d = wb_cnt_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          buf1_d      = st_in1;
          buf2_d      = st_in2;
          buf3_d      = st_in3;
          issue_cnt_d = 5'd0;
          wb_cnt_d    = 5'd0;
          state_d     = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (rnd_valid) begin
          issue_s        = 1'b1;
          tag_in_s.valid = 1'b1;
          tag_in_s.idx   = issue_cnt_q[3:0];
          issue_cnt_d    = issue_cnt_q + 5'd1;
          if (issue_cnt_q == 5'(NUM_NIB - 1)) begin
            state_d = DRAIN;
          end else begin
            state_d = ISSUE;
          end
        end else begin
          state_d = ISSUE;
        end
      end
      DRAIN: begin
        if (wb_cnt_d == 5'(NUM_NIB)) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      issue_cnt_q <= 5'd0;
      wb_cnt_q    <= 5'd0;
      buf1_q      <= 64'd0;
      buf2_q      <= 64'd0;
      buf3_q      <= 64'd0;
      st1_q       <= 64'd0;
      st2_q       <= 64'd0;
      st3_q       <= 64'd0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      wb_cnt_q    <= wb_cnt_d;
      buf1_q      <= buf1_d;
      buf2_q      <= buf2_d;
      buf3_q      <= buf3_d;
      st1_q       <= st1_d;
      st2_q       <= st2_d;
      st3_q       <= st3_d;
    end
  end

  sbox_tag_pipe #(.LAT(LAT)) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in_s),
    .tag_out (tag_out_s)
  );

`ifdef SBOX_IDLE_ZERO_EN
  // Quiet S-box inputs whenever no nibble is issued.
  always_comb begin
    if (issue_s) begin
      sb_in1 = nib1_s;
      sb_in2 = nib2_s;
      sb_in3 = nib3_s;
    end else begin
      sb_in1 = 4'h0;
      sb_in2 = 4'h0;
      sb_in3 = 4'h0;
    end
  end
`else
  logic [NIB_W-1:0] last1_q, last2_q, last3_q;

  // Hold the most recently issued nibble on the S-box inputs.
  always_comb begin
    if (issue_s) begin
      sb_in1 = nib1_s;
      sb_in2 = nib2_s;
      sb_in3 = nib3_s;
    end else begin
      sb_in1 = last1_q;
      sb_in2 = last2_q;
      sb_in3 = last3_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last1_q <= 4'h0;
      last2_q <= 4'h0;
      last3_q <= 4'h0;
    end else begin
      last1_q <= sb_in1;
      last2_q <= sb_in2;
      last3_q <= sb_in3;
    end
  end
`endif

  assign busy      = (state_q == ISSUE) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign rnd_ready = issue_s;
  assign sb_r      = rnd;
  assign st_out1   = st1_q;
  assign st_out2   = st2_q;
  assign st_out3   = st3_q;

endmodule

// File: tb/tb_midori_sbox_sched.sv
// Self-checking bench: randomized runs against a behavioural schedule/S-box reference.
module tb_midori_sbox_sched;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst, start, rnd_valid, rnd_ready, busy, done;
  logic [63:0] st_in1, st_in2, st_in3, st_out1, st_out2, st_out3;
  logic [7:0]  rnd, sb_r;
  logic [3:0]  sb_in1, sb_in2, sb_in3, sb_out1, sb_out2, sb_out3;
  logic [3:0]  o1, o2, o3;
  logic [11:0] sbp [LAT];
  logic [11:0] last_nib;
  int          n_cmp = 0;
  int          n_mis = 0;

  always #5 clk = ~clk;

  midori_sbox_sched #(.LAT(LAT), .NUM_NIB(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .st_in1(st_in1), .st_in2(st_in2), .st_in3(st_in3),
    .busy(busy), .done(done),
    .st_out1(st_out1), .st_out2(st_out2), .st_out3(st_out3),
    .rnd(rnd), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .sb_in1(sb_in1), .sb_in2(sb_in2), .sb_in3(sb_in3), .sb_r(sb_r),
    .sb_out1(sb_out1), .sb_out2(sb_out2), .sb_out3(sb_out3)
  );

  function automatic logic [3:0] sb4(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC;  4'h1: return 4'hA;  4'h2: return 4'hD;  4'h3: return 4'h3;
      4'h4: return 4'hE;  4'h5: return 4'hB;  4'h6: return 4'hF;  4'h7: return 4'h7;
      4'h8: return 4'h8;  4'h9: return 4'h9;  4'hA: return 4'h1;  4'hB: return 4'h5;
      4'hC: return 4'h0;  4'hD: return 4'h2;  4'hE: return 4'h4;  default: return 4'h6;
    endcase
  endfunction

  function automatic logic [63:0] sbox64(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = sb4(x[4*i +: 4]);
    return r;
  endfunction

  // Masked S-box stand-in: fresh re-masking from sb_r, fixed LAT-cycle delay.
  assign o2 = sb_in2 ^ sb_r[3:0];
  assign o3 = sb_in3 ^ sb_r[7:4];
  assign o1 = sb4(sb_in1 ^ sb_in2 ^ sb_in3) ^ o2 ^ o3;

  always_ff @(posedge clk) begin
    sbp[0] <= {o1, o2, o3};
    for (int i = 1; i < LAT; i++) sbp[i] <= sbp[i-1];
  end
  assign {sb_out1, sb_out2, sb_out3} = sbp[LAT-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // One substitution run; mode 0 = rnd always valid, 1 = 0101.., 2 = random.
  task automatic run_case(input string name, input logic [63:0] s1, input logic [63:0] s2,
                          input logic [63:0] s3, input int mode, input bit hold,
                          output logic [63:0] res, output int done_at);
    bit          vld [257];
    int          cnt, last_issue, exp_done, issued, pulses;
    bit          exp_rdy;
    logic [11:0] exp_sb;
    cnt = 0;
    last_issue = 0;
    for (int n = 1; n <= 256; n++) begin
      case (mode)
        0:       vld[n] = 1'b1;
        1:       vld[n] = (n % 2 == 0);
        default: vld[n] = (n > 150) ? 1'b1 : ($urandom_range(3, 0) != 0);
      endcase
      if (last_issue == 0 && vld[n]) begin
        cnt++;
        if (cnt == 16) last_issue = n;
      end
    end
    exp_done = last_issue + LAT + 1;

    @(negedge clk);
    start = 1'b1; st_in1 = s1; st_in2 = s2; st_in3 = s3;
    rnd_valid = 1'($urandom_range(1, 0)); rnd = 8'($urandom);
    #1;
    check({name, ".idle_busy"}, 64'(busy), 64'd0);
    check({name, ".idle_ready"}, 64'(rnd_ready), 64'd0);
`ifdef SBOX_IDLE_ZERO_EN
    check({name, ".idle_sbin"}, 64'({sb_in1, sb_in2, sb_in3}), 64'd0);
`else
    check({name, ".idle_sbin"}, 64'({sb_in1, sb_in2, sb_in3}), 64'(last_nib));
`endif
    issued = 0; pulses = 0; done_at = -1;
    for (int n = 1; n <= exp_done + 2; n++) begin
      @(negedge clk);
      start = hold && (n <= exp_done);
      if (hold && n == 20) begin
        st_in1 = {$urandom, $urandom}; st_in2 = {$urandom, $urandom}; st_in3 = {$urandom, $urandom};
      end
      rnd_valid = vld[n]; rnd = 8'($urandom);
      #1;
      exp_rdy = (issued < 16) && vld[n];
      if (exp_rdy) begin
        exp_sb = {s1[4*issued +: 4], s2[4*issued +: 4], s3[4*issued +: 4]};
        last_nib = exp_sb;
        issued++;
      end else begin
`ifdef SBOX_IDLE_ZERO_EN
        exp_sb = 12'h0;
`else
        exp_sb = last_nib;
`endif
      end
      check($sformatf("%s.ready@%0d", name, n), 64'(rnd_ready), 64'(exp_rdy));
      check($sformatf("%s.sb_r@%0d", name, n), 64'(sb_r), 64'(rnd));
      check($sformatf("%s.sb_in@%0d", name, n), 64'({sb_in1, sb_in2, sb_in3}), 64'(exp_sb));
      check($sformatf("%s.busy@%0d", name, n), 64'(busy), 64'(n < exp_done));
      check($sformatf("%s.done@%0d", name, n), 64'(done), 64'(n == exp_done));
      if (done === 1'b1) begin
        pulses++;
        if (done_at < 0) done_at = n;
      end
    end
    check({name, ".pulses"}, 64'(pulses), 64'd1);
    res = st_out1 ^ st_out2 ^ st_out3;
  endtask

  logic [63:0] x, a2, a3, res;
  int          d_a, d_c, d_tmp;

  initial begin
    rst = 1'b1; start = 1'b0; rnd_valid = 1'b0; rnd = 8'd0;
    st_in1 = 64'd0; st_in2 = 64'd0; st_in3 = 64'd0;
    last_nib = 12'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.st_out", st_out1 | st_out2 | st_out3, 64'd0);
    check("rst.sb_in", 64'({sb_in1, sb_in2, sb_in3}), 64'd0);

    run_case("zero", 64'd0, 64'd0, 64'd0, 0, 1'b0, res, d_a);
    check("zero.result", res, 64'hCCCCCCCCCCCCCCCC);
    check("zero.done_cycle", 64'(d_a), 64'(17 + LAT));

    x  = 64'h0123456789ABCDEF;
    a2 = {$urandom, $urandom};
    a3 = {$urandom, $urandom};
    run_case("vec", x ^ a2 ^ a3, a2, a3, 0, 1'b0, res, d_tmp);
    check("vec.result", res, 64'hCAD3EBF789150246);
    check("vec.share1_masked", 64'(st_out1 != 64'hCAD3EBF789150246), 64'd1);
    check("vec.share2_masked", 64'(st_out2 != 64'hCAD3EBF789150246), 64'd1);
    check("vec.share3_masked", 64'(st_out3 != 64'hCAD3EBF789150246), 64'd1);

    run_case("alt", x ^ a2 ^ a3, a2, a3, 1, 1'b0, res, d_c);
    check("alt.result", res, 64'hCAD3EBF789150246);
    check("alt.delay", 64'(d_c - d_a), 64'd16);

    x = {$urandom, $urandom}; a2 = {$urandom, $urandom}; a3 = {$urandom, $urandom};
    run_case("hold", x ^ a2 ^ a3, a2, a3, 2, 1'b1, res, d_tmp);
    check("hold.result", res, sbox64(x));

    x = {$urandom, $urandom}; a2 = {$urandom, $urandom}; a3 = {$urandom, $urandom};
    run_case("after", x ^ a2 ^ a3, a2, a3, 2, 1'b0, res, d_tmp);
    check("after.result", res, sbox64(x));

    // Reset while issue_cnt == 7; in-flight S-box results must be dropped.
    @(negedge clk);
    start = 1'b1; st_in1 = {$urandom, $urandom}; st_in2 = {$urandom, $urandom};
    st_in3 = {$urandom, $urandom}; rnd_valid = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      start = 1'b0; rnd = 8'($urandom); rst = (n == 8);
    end
    @(negedge clk);
    rst = 1'b0; rnd = 8'($urandom);
    #1;
    last_nib = 12'h0;
    check("midrst.busy", 64'(busy), 64'd0);
    check("midrst.ready", 64'(rnd_ready), 64'd0);
    check("midrst.sb_in", 64'({sb_in1, sb_in2, sb_in3}), 64'd0);
    for (int n = 0; n < 10; n++) begin
      check($sformatf("midrst.st_out@%0d", n), st_out1 | st_out2 | st_out3, 64'd0);
      check($sformatf("midrst.done@%0d", n), 64'(done), 64'd0);
      @(negedge clk);
      #1;
    end

    for (int k = 0; k < 3; k++) begin
      x = {$urandom, $urandom}; a2 = {$urandom, $urandom}; a3 = {$urandom, $urandom};
      run_case($sformatf("rand%0d", k), x ^ a2 ^ a3, a2, a3, 2, 1'b0, res, d_tmp);
      check($sformatf("rand%0d.result", k), res, sbox64(x));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
